// File: rtl/vec_pkg.sv
// Shared lane geometry and operation encodings for the vector execute sequencer.
package vec_pkg;
    localparam int NUM_LANES      = 16;
    localparam int LANES_PER_BEAT = 4;
    localparam int LANE_W         = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;
endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU; all arithmetic wraps modulo 2^32.
module vec_lane_alu
    import vec_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y
);
    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            ALU_MUL: y = a * b;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/vec_exec_sequencer.sv
// Execute-stage sequencer: scalar ops finish in one cycle, vector ops are
// processed LANES_PER_BEAT lanes per cycle through a shared bank of lane ALUs.
module vec_exec_sequencer #(
    parameter int NUM_LANES      = vec_pkg::NUM_LANES,
    parameter int LANES_PER_BEAT = vec_pkg::LANES_PER_BEAT
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 ValidE,
    input  logic                                 FlushE,
    input  logic                                 v_s_e,
    input  logic [NUM_LANES*vec_pkg::LANE_W-1:0] RD1E,
    input  logic [NUM_LANES*vec_pkg::LANE_W-1:0] RD2E,
    input  logic [vec_pkg::LANE_W-1:0]           ExtImmE,
    input  logic                                 ALUSrcE,
    input  logic [2:0]                           ALUControlE,
    input  logic                                 RegWriteE,
    input  logic [3:0]                           WA3E,
    output logic                                 ReadyE,
    output logic                                 StallD,
    output logic                                 ValidM,
    output logic [NUM_LANES*vec_pkg::LANE_W-1:0] ResultM,
    output logic                                 RegWriteM,
    output logic [3:0]                           WA3M,
    output logic [1:0]                           state_dbg
);
    localparam int W         = vec_pkg::LANE_W;
    localparam int DW        = NUM_LANES * W;
    localparam int NUM_BEATS = NUM_LANES / LANES_PER_BEAT;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int BEAT_BITS = LANES_PER_BEAT * W;

    vec_pkg::seq_state_e state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [DW-1:0]       a_q, b_q, res_q, res_next;
    logic [W-1:0]        imm_q;
    logic                src_q, wr_q;
    logic [2:0]          op_q;
    logic [3:0]          wa_q;
    logic [BEAT_BITS-1:0] alu_a, alu_b, alu_y;
    logic [2:0]          alu_op;
    logic                busy, accept, last_beat;

    // Handshake: an op transfers on a cycle where ValidE=1 and ReadyE=1 with no
    // FlushE; ReadyE depends only on state, StallD is its complement.
    assign busy      = (state_q == vec_pkg::ST_BUSY);
    assign ReadyE    = ~busy;
    assign StallD    = busy;
    assign accept    = ValidE & ReadyE & ~FlushE;
    assign last_beat = (beat_q == BEAT_W'(NUM_BEATS - 1));
    assign state_dbg = state_q;

    // While busy the ALUs see the captured beat; otherwise live lane 0..N for scalar.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = busy ? op_q : ALUControlE;
        for (int i = 0; i < LANES_PER_BEAT; i++) begin
            if (busy) begin
                alu_a[i*W +: W] = a_q[(int'(beat_q)*LANES_PER_BEAT + i)*W +: W];
                alu_b[i*W +: W] = src_q ? imm_q : b_q[(int'(beat_q)*LANES_PER_BEAT + i)*W +: W];
            end else begin
                alu_a[i*W +: W] = RD1E[i*W +: W];
                alu_b[i*W +: W] = ALUSrcE ? ExtImmE : RD2E[i*W +: W];
            end
        end
    end

    always_comb begin
        res_next = res_q;
        res_next[int'(beat_q)*BEAT_BITS +: BEAT_BITS] = alu_y;
    end

    for (genvar g = 0; g < LANES_PER_BEAT; g++) begin : g_lane
        vec_lane_alu u_alu (
            .op (alu_op),
            .a  (alu_a[g*W +: W]),
            .b  (alu_b[g*W +: W]),
            .y  (alu_y[g*W +: W])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= vec_pkg::ST_IDLE;
            beat_q    <= '0;
            ValidM    <= 1'b0;
            ResultM   <= '0;
            RegWriteM <= 1'b0;
            WA3M      <= '0;
        end else begin
            ValidM <= 1'b0;
            case (state_q)
                vec_pkg::ST_BUSY: begin
                    if (FlushE) begin
                        state_q <= vec_pkg::ST_IDLE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            state_q   <= vec_pkg::ST_DONE;
                            ValidM    <= 1'b1;
                            ResultM   <= res_next;
                            RegWriteM <= wr_q;
                            WA3M      <= wa_q;
                        end
                    end
                end
                default: begin
                    if (accept && v_s_e) begin
                        state_q <= vec_pkg::ST_BUSY;
                        beat_q  <= '0;
                    end else if (accept) begin
                        state_q   <= vec_pkg::ST_DONE;
                        ValidM    <= 1'b1;
                        ResultM   <= DW'(alu_y[W-1:0]);
                        RegWriteM <= RegWriteE;
                        WA3M      <= WA3E;
                    end else begin
                        state_q <= vec_pkg::ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Operand capture and beat accumulation; never read outside BUSY, so no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_q   <= RD1E;
            b_q   <= RD2E;
            imm_q <= ExtImmE;
            src_q <= ALUSrcE;
            op_q  <= ALUControlE;
            wr_q  <= RegWriteE;
            wa_q  <= WA3E;
        end
        if (busy) begin
            res_q <= res_next;
        end
    end
endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Scoreboard bench: driver pushes expected results on accept, monitor pops on ValidM.
module tb_vec_exec_sequencer;
    localparam int NL = 16;
    localparam int W  = 32;
    localparam int DW = NL * W;
    localparam int EW = DW + 5;
    localparam int NB = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ValidE = 1'b0, FlushE = 1'b0, v_s_e = 1'b0, ALUSrcE = 1'b0, RegWriteE = 1'b0;
    logic [DW-1:0] RD1E = '0, RD2E = '0;
    logic [W-1:0]  ExtImmE = '0;
    logic [2:0]    ALUControlE = '0;
    logic [3:0]    WA3E = '0;
    logic          ReadyE, StallD, ValidM, RegWriteM;
    logic [DW-1:0] ResultM;
    logic [3:0]    WA3M;
    logic [1:0]    state_dbg;

    vec_exec_sequencer dut (
        .CLK(CLK), .RST(RST), .ValidE(ValidE), .FlushE(FlushE), .v_s_e(v_s_e),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .RegWriteE(RegWriteE), .WA3E(WA3E),
        .ReadyE(ReadyE), .StallD(StallD), .ValidM(ValidM), .ResultM(ResultM),
        .RegWriteM(RegWriteM), .WA3M(WA3M), .state_dbg(state_dbg)
    );

    // Clock/reset
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    int busy_left = 0;
    logic [EW-1:0] exp_q[$];
    int exp_cyc_q[$];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one lane from the operation table, plain arithmetic.
    function automatic logic [W-1:0] lane_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [EW-1:0] expect_op(input bit vs, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [W-1:0] imm, input bit src, input logic [2:0] op,
                                                input bit rw, input logic [3:0] wa);
        logic [DW-1:0] r;
        int n;
        r = '0;
        n = vs ? NL : 1;
        for (int i = 0; i < n; i++)
            r[i*W +: W] = lane_ref(op, a[i*W +: W], src ? imm : b[i*W +: W]);
        return {rw, wa, r};
    endfunction

    // Driver: one cycle of stimulus, starting and ending 1 time unit after posedge.
    task automatic step(input bit v, input bit f, input bit vs, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [W-1:0] imm, input bit src, input logic [2:0] op, input bit rw, input logic [3:0] wa);
        bit exp_ready, acc;
        exp_ready = (busy_left == 0);
        ValidE = v; FlushE = f; v_s_e = vs; RD1E = a; RD2E = b; ExtImmE = imm;
        ALUSrcE = src; ALUControlE = op; RegWriteE = rw; WA3E = wa;
        check("ready", ReadyE, exp_ready);
        check("stall", StallD, !exp_ready);
        acc = v && exp_ready && !f;
        if (acc) begin
            exp_q.push_back(expect_op(vs, a, b, imm, src, op, rw, wa));
            exp_cyc_q.push_back(cyc + (vs ? NB + 1 : 1));
        end
        if (busy_left > 0) begin
            if (f) begin
                busy_left = 0;
                void'(exp_q.pop_back());
                void'(exp_cyc_q.pop_back());
            end else begin
                busy_left--;
            end
        end
        if (acc && vs) busy_left = NB;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, '0, '0, '0, 0, 3'd0, 0, 4'd0);
    endtask

    task automatic apply_reset(input int n);
        RST = 1'b1; ValidE = 1'b0; FlushE = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        busy_left = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_validm"}, ValidM, 0);
        check({tag, "_result"}, ResultM, 0);
        check({tag, "_wa3m"}, WA3M, 0);
        check({tag, "_regwritem"}, RegWriteM, 0);
        check({tag, "_readye"}, ReadyE, 1);
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] r;
        for (int i = 0; i < NL; i++)
            r[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
        return r;
    endfunction

    // Scoreboard monitor
    logic [EW-1:0] mon_exp;
    int mon_cyc;
    always @(negedge CLK) begin
        if (!RST && ValidM) begin
            if (exp_q.size() == 0) begin
                check("validm_unexpected", ValidM, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                check("result", {RegWriteM, WA3M, ResultM}, mon_exp);
                check("latency", cyc, mon_cyc);
            end
        end
    end

    initial begin
        logic [DW-1:0] va, vb, ones, big, twos;
        for (int i = 0; i < NL; i++) begin
            va[i*W +: W]   = W'(i);
            vb[i*W +: W]   = 32'd100;
            ones[i*W +: W] = 32'd1;
            big[i*W +: W]  = 32'hFFFF_FFFF;
            twos[i*W +: W] = 32'd2;
        end

        apply_reset(2);
        check_reset_outputs("reset");

        // Vector ADD, then scalar SUB 5-7, then vector SLL by immediate 0x24
        step(1, 0, 1, va, vb, '0, 0, 3'd0, 1, 4'd5);
        idle(7);
        step(1, 0, 0, DW'(32'd5), DW'(32'd7), '0, 0, 3'd1, 1, 4'd3);
        idle(2);
        step(1, 0, 1, ones, rand_vec(), 32'h24, 1, 3'd5, 0, 4'd9);
        idle(6);

        // ValidE held through DONE: second op accepted back-to-back
        repeat (6) step(1, 0, 1, va, vb, '0, 0, 3'd4, 1, 4'd7);
        idle(6);

        // Flush in cycle 2 of a vector op
        step(1, 0, 1, va, vb, '0, 0, 3'd0, 1, 4'd1);
        idle(1);
        step(0, 1, 0, '0, '0, '0, 0, 3'd0, 0, 4'd0);
        idle(6);

        // Flush in DONE blocks the accept, flush with valid in IDLE does too
        step(1, 0, 0, rand_vec(), rand_vec(), '0, 0, 3'd7, 1, 4'd2);
        step(1, 1, 1, va, vb, '0, 0, 3'd0, 1, 4'd4);
        step(1, 1, 0, va, vb, '0, 0, 3'd0, 1, 4'd4);
        idle(3);

        // Reset during a vector MUL, then rerun
        step(1, 0, 1, big, twos, '0, 0, 3'd7, 1, 4'd8);
        idle(2);
        apply_reset(1);
        check_reset_outputs("midop_reset");
        step(1, 0, 1, big, twos, '0, 0, 3'd7, 1, 4'd8);
        idle(6);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 rand_vec(), rand_vec(), ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 63)),
                 $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)));
        end
        idle(12);
        check("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
